// File: rtl/gpr_banked_mp_pkg.sv
// Shared definitions for the banked register file and the CSR file.
// Contents: bank-select width helper, bank-switch FSM encoding and the
// byte-merge function used by the write path and the read bypass.
package gpr_banked_mp_pkg;

  // Bank-switch FSM encoding. Plain constants keep the encoding stable for
  // legacy blocks that decode the state directly.
  typedef logic [1:0] bank_fsm_t;
  localparam bank_fsm_t ST_IDLE   = 2'd0;
  localparam bank_fsm_t ST_DRAIN  = 2'd1;
  localparam bank_fsm_t ST_SWITCH = 2'd2;

  // Widest word the byte-merge helper handles; callers zero-extend into it
  // and truncate the result back to their own width.
  localparam int MERGE_W  = 256;
  localparam int MERGE_BE = MERGE_W / 8;

  // A single bank still needs a one-bit select so ports never go zero-width.
  function automatic int calc_bank_w(input int num_bank);
    if (num_bank > 1) return $clog2(num_bank);
    return 1;
  endfunction

  // Replace the bytes of old_v whose enable is set with the bytes of new_v.
  function automatic logic [MERGE_W-1:0] byte_merge(input logic [MERGE_W-1:0]  old_v,
                                                    input logic [MERGE_W-1:0]  new_v,
                                                    input logic [MERGE_BE-1:0] be);
    logic [MERGE_W-1:0] r;
    r = old_v;
    for (int b = 0; b < MERGE_BE; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gpr_banked_mp_if.sv
// Register-file bus: read ports, writeback port, scoreboard issue and the
// bank-switch handshake.
// master: decode/writeback/control side; slave: the register file.
interface gpr_banked_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BANK_W = 1
);
  // read ports, port k at [k*W +: W]
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  // writeback
  logic                     we;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W/8-1:0]      wr_be;
  logic [DATA_W-1:0]        wr_data;
  // scoreboard issue
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic                     sb_ready;
  logic                     sb_err;
  // bank switch
  logic                     bank_req;
  logic [BANK_W-1:0]        bank_id;
  logic                     bank_ack;
  logic [BANK_W-1:0]        cur_bank;

  modport master (
    output rd_addr, we, wr_addr, wr_be, wr_data, sb_set, sb_addr, bank_req, bank_id,
    input  rd_data, rd_busy, sb_ready, sb_err, bank_ack, cur_bank
  );

  modport slave (
    input  rd_addr, we, wr_addr, wr_be, wr_data, sb_set, sb_addr, bank_req, bank_id,
    output rd_data, rd_busy, sb_ready, sb_err, bank_ack, cur_bank
  );
endinterface

// File: rtl/gpr_bypass_mux.sv
// One read port: write-to-read byte-merged bypass, zero-register forcing and
// scoreboard lookup. Purely combinational, zero latency, no backpressure.
// Ports: rd_addr_i/stored_i/busy_i from the storage, we/wr_* from writeback,
//        rd_data_o/rd_busy_o to decode.
module gpr_bypass_mux
  import gpr_banked_mp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]      rd_addr_i,
  input  logic [DATA_W-1:0]      stored_i,
  input  logic [2**ADDR_W-1:0]   busy_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [DATA_W/8-1:0]    wr_be_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  output logic [DATA_W-1:0]      rd_data_o,
  output logic                   rd_busy_o
);

  logic              is_zero;
  logic              hit;
  logic [DATA_W-1:0] merged;

  assign is_zero = (ZERO_REG != 0) && (rd_addr_i == '0);
  assign hit     = we_i && (wr_addr_i == rd_addr_i);
  assign merged  = DATA_W'(byte_merge(MERGE_W'(stored_i), MERGE_W'(wr_data_i),
                                      MERGE_BE'(wr_be_i)));

  // Busy comes from the registered scoreboard only; a same-cycle writeback
  // clears it at the edge, not in the read path.
  always_comb begin
    rd_data_o = stored_i;
    rd_busy_o = busy_i[rd_addr_i];
    if (hit) rd_data_o = merged;
    if (is_zero) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule

// File: rtl/gpr_banked_mp.sv
// Banked GPR file with byte-enable writeback, optional hardwired r0, per-register
// busy scoreboard and a drain-then-switch bank handshake.
// Latency: reads combinational; writes/scoreboard at the next edge; switch >= 2 cycles.
// Backpressure: sb_ready drops while a switch drains/completes; issue must hold sb_set.
// Ports: clk, reset (sync, active-high), bus (slave modport of gpr_banked_mp_if).
module gpr_banked_mp
  import gpr_banked_mp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_BANK = 2,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            reset,
  gpr_banked_mp_if.slave  bus
);

  localparam int BANK_W = calc_bank_w(NUM_BANK);
  localparam int NREG   = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_BANK][NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  bank_fsm_t         state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BANK_W-1:0] tgt_q, tgt_d;
  logic              sb_err_q, sb_err_d;

  logic              wr_ok;
  logic              set_ok;
  logic              sb_ready;
  logic              tgt_ok;
  logic [DATA_W-1:0] wr_merged;

  // Writes to a hardwired r0 are dropped, including their busy clear.
  assign wr_ok    = bus.we && !((ZERO_REG != 0) && (bus.wr_addr == '0));
  assign sb_ready = (state_q == ST_IDLE);
  assign set_ok   = bus.sb_set && sb_ready && !((ZERO_REG != 0) && (bus.sb_addr == '0));

  assign wr_merged = DATA_W'(byte_merge(MERGE_W'(regs_q[bank_q][bus.wr_addr]),
                                        MERGE_W'(bus.wr_data), MERGE_BE'(bus.wr_be)));

  // Out-of-range targets complete the handshake but leave the bank alone.
  generate
    if ((1 << BANK_W) == NUM_BANK) begin : g_tgt_pow2
      assign tgt_ok = 1'b1;
    end else begin : g_tgt_range
      assign tgt_ok = (int'(tgt_q) < NUM_BANK);
    end
  endgenerate

  // Scoreboard: clear first, then set, so a same-address issue wins over the
  // older writeback. An error needs the bit to stay busy across the edge.
  always_comb begin
    busy_d   = busy_q;
    sb_err_d = sb_err_q;
    if (wr_ok) busy_d[bus.wr_addr] = 1'b0;
    if (set_ok) begin
      if (busy_q[bus.sb_addr] && !(wr_ok && (bus.wr_addr == bus.sb_addr)))
        sb_err_d = 1'b1;
      busy_d[bus.sb_addr] = 1'b1;
    end
  end

  // Bank switch. DRAIN looks at busy_d so the writeback that empties the
  // scoreboard moves straight to SWITCH on the same edge.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    bank_d  = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.bank_req) begin
          tgt_d   = bus.bank_id;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (busy_d == '0) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (tgt_ok) bank_d = tgt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANK; b++) begin
        for (int r = 0; r < NREG; r++) begin
          regs_q[b][r] <= '0;
        end
      end
      busy_q   <= '0;
      state_q  <= ST_IDLE;
      bank_q   <= '0;
      tgt_q    <= '0;
      sb_err_q <= 1'b0;
    end else begin
      if (wr_ok) regs_q[bank_q][bus.wr_addr] <= wr_merged;
      busy_q   <= busy_d;
      state_q  <= state_d;
      bank_q   <= bank_d;
      tgt_q    <= tgt_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign bus.sb_ready = sb_ready;
  assign bus.sb_err   = sb_err_q;
  assign bus.bank_ack = (state_q == ST_SWITCH);
  assign bus.cur_bank = bank_q;

  // Read ports
  logic [DATA_W-1:0] stored_a  [NUM_RD];
  logic [DATA_W-1:0] rd_data_a [NUM_RD];
  logic              rd_busy_a [NUM_RD];

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign stored_a[k] = regs_q[bank_q][bus.rd_addr[k*ADDR_W +: ADDR_W]];

      gpr_bypass_mux #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
      ) u_mux (
        .rd_addr_i (bus.rd_addr[k*ADDR_W +: ADDR_W]),
        .stored_i  (stored_a[k]),
        .busy_i    (busy_q),
        .we_i      (bus.we),
        .wr_addr_i (bus.wr_addr),
        .wr_be_i   (bus.wr_be),
        .wr_data_i (bus.wr_data),
        .rd_data_o (rd_data_a[k]),
        .rd_busy_o (rd_busy_a[k])
      );
    end
  endgenerate

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      bus.rd_data[k*DATA_W +: DATA_W] = rd_data_a[k];
      bus.rd_busy[k]                  = rd_busy_a[k];
    end
  end

endmodule
